// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with optional parity checking and a
// first-word-fall-through receive FIFO with sticky error reporting.
// Build option: define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 majority
// of samples at os = target-1, target, target+1. The decision moves one tick later.
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV     = 27,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            Rst,
    input  logic                            rx_in,
    input  logic                            rd_en,
    input  logic                            clr_err,
    output logic [DATA_BITS-1:0]            rd_data,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun
);
    localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OsW   = $clog2(OVERSAMPLE + 1);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [OsW-1:0] HalfPt = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [OsW-1:0] FullPt = OsW'(OVERSAMPLE - 1);
    localparam logic           OddPar = (PARITY_MODE == 2);
`ifdef UART_RX_MAJORITY_EN
    // The decision lands one tick past the bit centre; restarting at 1 keeps the
    // next centre exactly OVERSAMPLE ticks after this one.
    localparam logic [OsW-1:0] OsRestart = OsW'(1);
`else
    localparam logic [OsW-1:0] OsRestart = OsW'(0);
`endif

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [1:0]           sync_q;
    logic [OsW-1:0]       os_q, os_d, target;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 tick, rx_s, samp_now, samp_val;
    logic                 push, set_ferr, set_perr;
    logic                 ferr_q, perr_q, ovr_q;
    logic [CntW-1:0]      wr_q, rd_q;
    logic                 do_push, do_pop;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    assign rx_s   = sync_q[1];
    assign target = (state_q == StStart) ? HalfPt : FullPt;

    // Free-running oversample tick divider.
    always_comb begin
        tick  = (div_q == DivW'(CLK_DIV - 1));
        div_d = tick ? '0 : div_q + DivW'(1);
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;

    // Capture the two early votes; the third is the live line at the decision tick.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            maj_q <= 2'b11;
        end else if (tick) begin
            if (os_q == target - OsW'(1)) maj_q[0] <= rx_s;
            if (os_q == target)           maj_q[1] <= rx_s;
        end
    end

    assign samp_now = tick && (os_q == target + OsW'(1));
    assign samp_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
    assign samp_now = tick && (os_q == target);
    assign samp_val = rx_s;
`endif

    // Receive FSM next-state: frame the bits and decide push/discard at mid-stop.
    always_comb begin
        state_d   = state_q;
        os_d      = tick ? os_q + OsW'(1) : os_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        push      = 1'b0;
        set_ferr  = 1'b0;
        set_perr  = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick && !rx_s) begin
                    state_d = StStart;
                    os_d    = '0;
                end
            end
            StStart: begin
                if (samp_now) begin
                    if (samp_val) begin
                        state_d = StIdle;  // glitch, not a start bit
                    end else begin
                        state_d   = StData;
                        os_d      = OsRestart;
                        bit_d     = '0;
                        par_bad_d = 1'b0;
                    end
                end
            end
            StData: begin
                if (samp_now) begin
                    shift_d = {samp_val, shift_q[DATA_BITS-1:1]};
                    os_d    = OsRestart;
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        state_d = (PARITY_MODE != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (samp_now) begin
                    par_bad_d = samp_val != ((^shift_q) ^ OddPar);
                    os_d      = OsRestart;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (samp_now) begin
                    state_d = StIdle;
                    if (!samp_val)     set_ferr = 1'b1;
                    else if (par_bad_q) set_perr = 1'b1;
                    else               push     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO status and first-word-fall-through head.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]) && (wr_q[AddrW] != rd_q[AddrW]);
        count   = wr_q - rd_q;
        do_pop  = rd_en && !empty;
        do_push = push && (!full || do_pop);
        rd_data = empty ? '0 : mem_q[rd_q[AddrW-1:0]];
    end

    // Receiver, FIFO pointer and sticky flag state.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sync_q    <= 2'b11;
            div_q     <= '0;
            state_q   <= StIdle;
            os_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_in};
            div_q     <= div_d;
            state_q   <= state_d;
            os_q      <= os_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            if (do_push) wr_q <= wr_q + CntW'(1);
            if (do_pop)  rd_q <= rd_q + CntW'(1);
            // Set beats a coincident clear.
            if (set_ferr)     ferr_q <= 1'b1;
            else if (clr_err) ferr_q <= 1'b0;
            if (set_perr)     perr_q <= 1'b1;
            else if (clr_err) perr_q <= 1'b0;
            if (push && full && !do_pop) ovr_q <= 1'b1;
            else if (clr_err)            ovr_q <= 1'b0;
        end
    end

    // FIFO storage; not reset, only read while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AddrW-1:0]] <= shift_q;
    end

    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 depth-4 instance and an 8E1 depth-16 instance,
// CLK_DIV=2, OVERSAMPLE=16, 10 ns clock (32 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int BitCyc = 32;
`ifdef UART_RX_MAJORITY_EN
    localparam int MajLag = 2;
`else
    localparam int MajLag = 0;
`endif

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       rx_a = 1'b1, rd_a = 1'b0, clr_a = 1'b0;
    logic       rx_p = 1'b1, rd_p = 1'b0, clr_p = 1'b0;
    logic [7:0] data_a, data_p;
    logic       empty_a, full_a, ferr_a, perr_a, ovr_a;
    logic       empty_p, full_p, ferr_p, perr_p, ovr_p;
    logic [2:0] count_a;
    logic [4:0] count_p;
    int         checks = 0;
    int         failures = 0;
    int         cyc;
    logic [7:0] exp_a[$];
    logic [7:0] exp_p[$];

    uart_rx_fifo #(.CLK_DIV(2), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_MODE(0),
                   .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .Rst(Rst), .rx_in(rx_a), .rd_en(rd_a), .clr_err(clr_a),
        .rd_data(data_a), .empty(empty_a), .full(full_a), .count(count_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a)
    );

    uart_rx_fifo #(.CLK_DIV(2), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_MODE(1),
                   .FIFO_DEPTH(16)) dut_p (
        .clk(clk), .Rst(Rst), .rx_in(rx_p), .rd_en(rd_p), .clr_err(clr_p),
        .rd_data(data_p), .empty(empty_p), .full(full_p), .count(count_p),
        .frame_err(ferr_p), .parity_err(perr_p), .overrun(ovr_p)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the tick is high in odd-numbered cycles.
    always @(posedge clk or posedge Rst) begin
        if (Rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx_a = v;
    endtask

    task automatic hold_bit(input bit sel, input logic v);
        set_rx(sel, v);
        idle(BitCyc);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input logic par, input logic stop);
        hold_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
        if (par_en) hold_bit(sel, par);
        hold_bit(sel, stop);
        set_rx(sel, 1'b1);
    endtask

    task automatic pulse_rd_a();
        rd_a = 1'b1;
        idle(1);
        rd_a = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({empty_a, full_a, count_a, data_a, ferr_a, perr_a, ovr_a} !==
            {1'b1, 1'b0, 3'd0, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_a: got e=%b f=%b c=%0d d=%h err=%b%b%b, want 1 0 0 00 000",
                     empty_a, full_a, count_a, data_a, ferr_a, perr_a, ovr_a);
        end
        checks++;
        if ({empty_p, full_p, count_p, data_p, ferr_p, perr_p, ovr_p} !==
            {1'b1, 1'b0, 5'd0, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_p: got e=%b f=%b c=%0d d=%h err=%b%b%b, want 1 0 0 00 000",
                     empty_p, full_p, count_p, data_p, ferr_p, perr_p, ovr_p);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pats [3];
        logic [7:0] e;
        pats = '{8'h00, 8'hA5, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            exp_a.push_back(pats[i]);
            send_frame(1'b0, pats[i], 1'b0, 1'b0, 1'b1);
        end
        idle(4);
        checks++;
        if ({count_a, ferr_a, perr_a, ovr_a} !== {3'd3, 3'b000}) begin
            failures++;
            $display("FAIL b2b_count: got c=%0d err=%b%b%b, want c=3 err=000",
                     count_a, ferr_a, perr_a, ovr_a);
        end
        while (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            checks++;
            if (empty_a !== 1'b0 || data_a !== e) begin
                failures++;
                $display("FAIL b2b_data: got e=%b d=%h, want e=0 d=%h", empty_a, data_a, e);
            end
            pulse_rd_a();
        end
        checks++;
        if (empty_a !== 1'b1) begin
            failures++;
            $display("FAIL b2b_empty: got %b, want 1", empty_a);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] e;
        rx_a = 1'b0;
        idle(8);
        rx_a = 1'b1;
        idle(2 * BitCyc);
        checks++;
        if ({count_a, ferr_a, perr_a, ovr_a} !== {3'd0, 3'b000}) begin
            failures++;
            $display("FAIL glitch: got c=%0d err=%b%b%b, want c=0 err=000",
                     count_a, ferr_a, perr_a, ovr_a);
        end
        exp_a.push_back(8'h81);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        idle(4);
        e = exp_a.pop_front();
        checks++;
        if (count_a !== 3'd1 || data_a !== e) begin
            failures++;
            $display("FAIL glitch_recover: got c=%0d d=%h, want c=1 d=%h", count_a, data_a, e);
        end
        pulse_rd_a();
    endtask

    task automatic test_frame_err();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(2 * BitCyc);
        checks++;
        if ({count_a, ferr_a, perr_a, ovr_a} !== {3'd0, 3'b100}) begin
            failures++;
            $display("FAIL frame_err_set: got c=%0d err=%b%b%b, want c=0 err=100",
                     count_a, ferr_a, perr_a, ovr_a);
        end
        clr_a = 1'b1;
        idle(1);
        clr_a = 1'b0;
        checks++;
        if (ferr_a !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_clr: got %b, want 0", ferr_a);
        end
    endtask

    task automatic test_parity();
        logic [7:0] e;
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        idle(4);
        checks++;
        if ({count_p, ferr_p, perr_p} !== {5'd0, 2'b01}) begin
            failures++;
            $display("FAIL parity_bad: got c=%0d ferr=%b perr=%b, want c=0 ferr=0 perr=1",
                     count_p, ferr_p, perr_p);
        end
        exp_p.push_back(8'h07);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle(4);
        e = exp_p.pop_front();
        checks++;
        if (count_p !== 5'd1 || empty_p !== 1'b0 || data_p !== e) begin
            failures++;
            $display("FAIL parity_good: got c=%0d e=%b d=%h, want c=1 e=0 d=%h",
                     count_p, empty_p, data_p, e);
        end
        rd_p = 1'b1;
        idle(1);
        rd_p = 1'b0;
        checks++;
        if (empty_p !== 1'b1) begin
            failures++;
            $display("FAIL parity_pop: got empty=%b, want 1", empty_p);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] pats [5];
        logic [7:0] e;
        int n0, d, p;
        pats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            if (exp_a.size() < 4) exp_a.push_back(pats[i]);
            send_frame(1'b0, pats[i], 1'b0, 1'b0, 1'b1);
        end
        idle(4);
        checks++;
        if ({full_a, count_a, ovr_a} !== {1'b1, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL overrun_set: got f=%b c=%0d ovr=%b, want 1 4 1",
                     full_a, count_a, ovr_a);
        end
        clr_a = 1'b1;
        idle(1);
        clr_a = 1'b0;
        checks++;
        if (ovr_a !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clr: got %b, want 0", ovr_a);
        end
        // Start detected on the first odd cycle once the synchronizer shows 0;
        // stop is sampled 304 clk later and pushed at the end of that cycle.
        n0 = cyc;
        d  = ((n0 + 2) % 2 == 1) ? n0 + 2 : n0 + 3;
        p  = d + 304 + MajLag;
        exp_a.push_back(8'h66);
        fork
            send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
            begin
                repeat (p - cyc) @(posedge clk);
                #1;
                e = exp_a.pop_front();
                checks++;
                if (full_a !== 1'b1 || data_a !== e) begin
                    failures++;
                    $display("FAIL coincident_head: got f=%b d=%h, want f=1 d=%h",
                             full_a, data_a, e);
                end
                pulse_rd_a();
            end
        join
        idle(4);
        checks++;
        if ({full_a, count_a, ovr_a} !== {1'b1, 3'd4, 1'b0}) begin
            failures++;
            $display("FAIL coincident_count: got f=%b c=%0d ovr=%b, want 1 4 0",
                     full_a, count_a, ovr_a);
        end
        while (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            checks++;
            if (empty_a !== 1'b0 || data_a !== e) begin
                failures++;
                $display("FAIL overrun_data: got e=%b d=%h, want e=0 d=%h", empty_a, data_a, e);
            end
            pulse_rd_a();
        end
    endtask

    task automatic test_rst_mid_frame();
        logic [7:0] e;
        exp_a.push_back(8'h12);
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        exp_a.push_back(8'h34);
        send_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (count_a !== 3'd2) begin
            failures++;
            $display("FAIL rst_pre_count: got %0d, want 2", count_a);
        end
        rx_a = 1'b0;
        idle(2 * BitCyc + BitCyc / 2);
        Rst  = 1'b1;
        rx_a = 1'b1;
        idle(2);
        Rst  = 1'b0;
        exp_a.delete();
        checks++;
        if ({empty_a, count_a, data_a, ferr_a, perr_a, ovr_a} !==
            {1'b1, 3'd0, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL rst_mid_frame: got e=%b c=%0d d=%h err=%b%b%b, want 1 0 00 000",
                     empty_a, count_a, data_a, ferr_a, perr_a, ovr_a);
        end
        checks++;
        if (perr_p !== 1'b0) begin
            failures++;
            $display("FAIL rst_clears_perr: got %b, want 0", perr_p);
        end
        idle(BitCyc);
        exp_a.push_back(8'h5A);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(4);
        e = exp_a.pop_front();
        checks++;
        if (count_a !== 3'd1 || data_a !== e) begin
            failures++;
            $display("FAIL rst_recover: got c=%0d d=%h, want c=1 d=%h", count_a, data_a, e);
        end
        pulse_rd_a();
    endtask

    initial begin
        idle(3);
        test_reset();
        Rst = 1'b0;
        idle(4);
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_parity();
        test_overrun();
        test_rst_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
